fetch_stage: RTL and testbench

- Pipeline front end that consumes the hazard unit's stallF/stallD/PCsrcD decisions.
- Holds the fetch PC and drives a single-outstanding instruction-memory request/response handshake.
- Buffers a returned instruction while the pipe is stalled, and discards stale responses after a branch redirect.
- Owns the IF/ID pipeline register. Raises fetch_busy so memory latency can be merged into the global stall.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/if_id_reg.sv | 58 +++++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int PC_STEP_DEF = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall holds, flush and bubble insert a NOP, load captures fetch.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_plus_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus_q, pc_plus_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pc_plus_d = pc_plus_q;
        valid_d   = valid_q;
        if (stall_i) begin
            instr_d   = instr_q;
        end else if (flush_i) begin
            instr_d   = XLEN'(NOP_INSTR);
            valid_d   = 1'b0;
        end else if (load_i) begin
            instr_d   = instr_i;
            pc_plus_d = pc_plus_i;
            valid_d   = 1'b1;
        end else begin
            instr_d   = XLEN'(NOP_INSTR);
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            pc_plus_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_plus_q <= pc_plus_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_plus_o = pc_plus_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC, single-outstanding imem handshake, stall buffering and redirect draining.
// Optional FETCH_STAT_EN adds saturating bubble/redirect counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            PCsrcD,
    input  logic [XLEN-1:0] PCBranchD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD,
`ifdef FETCH_STAT_EN
    output logic [31:0]     stat_bubbles,
    output logic [31:0]     stat_redirects,
`endif
    output logic            fetch_busy
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic [XLEN-1:0] instr_buf_q, instr_buf_d;

    logic            redirect;
    logic            avail;
    logic            deliver;
    logic [XLEN-1:0] deliver_instr;
    logic [XLEN-1:0] pc_next;

    assign redirect      = PCsrcD & ~stallD;
    assign avail         = ((state_q == ST_FETCH) & imem_ready) | (state_q == ST_HOLD);
    assign deliver       = avail & ~stallF & ~redirect;
    assign deliver_instr = (state_q == ST_HOLD) ? instr_buf_q : imem_rdata;
    assign pc_next       = req_addr_q + XLEN'(PC_STEP);

    assign imem_req   = (state_q == ST_FETCH) | (state_q == ST_DRAIN);
    assign imem_addr  = req_addr_q;
    // Stall inputs are deliberately excluded so fetch_busy can feed stallF without a loop.
    assign fetch_busy = ((state_q == ST_FETCH) & ~imem_ready) | (state_q == ST_DRAIN);

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        pending_pc_d = pending_pc_q;
        instr_buf_d  = instr_buf_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        req_addr_d = PCBranchD;
                    end else if (!stallF) begin
                        req_addr_d = pc_next;
                    end else begin
                        instr_buf_d = imem_rdata;
                        state_d     = ST_HOLD;
                    end
                end else if (redirect) begin
                    pending_pc_d = PCBranchD;
                    state_d      = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    req_addr_d = PCBranchD;
                    state_d    = ST_FETCH;
                end else if (!stallF) begin
                    req_addr_d = pc_next;
                    state_d    = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // A redirect landing with the stale response still wins over the older target.
                if (imem_ready) begin
                    req_addr_d = redirect ? PCBranchD : pending_pc_q;
                    state_d    = ST_FETCH;
                end else if (redirect) begin
                    pending_pc_d = PCBranchD;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            req_addr_q  <= RESET_PC;
            instr_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            instr_buf_q <= instr_buf_d;
        end
        pending_pc_q <= pending_pc_d;
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stallD),
        .flush_i   (redirect),
        .load_i    (deliver),
        .instr_i   (deliver_instr),
        .pc_plus_i (pc_next),
        .instr_o   (InstrD),
        .pc_plus_o (PCPlus4D),
        .valid_o   (validD)
    );

`ifdef FETCH_STAT_EN
    logic [31:0] bubbles_q, redirects_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubbles_q   <= '0;
            redirects_q <= '0;
        end else begin
            if (!stallD && !redirect && !deliver) bubbles_q <= sat_inc32(bubbles_q);
            if (redirect) redirects_q <= sat_inc32(redirects_q);
        end
    end

    assign stat_bubbles   = bubbles_q;
    assign stat_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, latency, stall hold, drain, stalled redirect, reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            stallF, stallD, PCsrcD;
    logic [XLEN-1:0] PCBranchD;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] rdata_man;
    logic            echo;
    logic [XLEN-1:0] InstrD, PCPlus4D;
    logic            validD, fetch_busy;
`ifdef FETCH_STAT_EN
    logic [31:0]     stat_bubbles, stat_redirects;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = echo ? imem_addr : rdata_man;

    fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stallF     (stallF),
        .stallD     (stallD),
        .PCsrcD     (PCsrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .validD     (validD),
`ifdef FETCH_STAT_EN
        .stat_bubbles   (stat_bubbles),
        .stat_redirects (stat_redirects),
`endif
        .fetch_busy (fetch_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock; outputs settle 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; PCsrcD = 1'b0; PCBranchD = '0;
        imem_ready = 1'b0; rdata_man = '0; echo = 1'b0;

        // 1: reset then zero-wait streaming
        do_reset();
        chk("rst_validD", {31'b0, validD}, 32'h0);
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h1);
        echo = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("zw_InstrD", InstrD, 32'(4 * i));
            chk("zw_validD", {31'b0, validD}, 32'h1);
            chk("zw_PCPlus4D", PCPlus4D, 32'(4 * i + 4));
            chk("zw_addr", imem_addr, 32'(4 * i + 4));
        end

        // 2: three-cycle latency
        do_reset();
        echo = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lat_busy", {31'b0, fetch_busy}, 32'h1);
            chk("lat_addr0", imem_addr, 32'h0);
            step();
            chk("lat_bubble", {31'b0, validD}, 32'h0);
        end
        imem_ready = 1'b1; rdata_man = 32'hA0;
        #1;
        chk("lat_busy_rdy", {31'b0, fetch_busy}, 32'h0);
        step();
        chk("lat_InstrD", InstrD, 32'hA0);
        chk("lat_validD", {31'b0, validD}, 32'h1);
        chk("lat_addr4", imem_addr, 32'h4);
        imem_ready = 1'b0;
        step();
        chk("lat_bubble2", {31'b0, validD}, 32'h0);

        // 3: response for addr 8 lands under a two-cycle stall
        imem_ready = 1'b1; rdata_man = 32'h44;
        step();
        chk("hold_pre_addr", imem_addr, 32'h8);
        rdata_man = 32'h8; stallF = 1'b1; stallD = 1'b1;
        step();
        imem_ready = 1'b0; rdata_man = 32'hDEAD;
        #1;
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_busy", {31'b0, fetch_busy}, 32'h0);
        chk("hold_InstrD", InstrD, 32'h44);
        step();
        chk("hold_req2", {31'b0, imem_req}, 32'h0);
        chk("hold_InstrD2", InstrD, 32'h44);
        stallF = 1'b0; stallD = 1'b0;
        step();
        chk("hold_out", InstrD, 32'h8);
        chk("hold_valid", {31'b0, validD}, 32'h1);
        chk("hold_PCPlus4D", PCPlus4D, 32'hC);
        chk("hold_next_addr", imem_addr, 32'hC);
        chk("hold_next_req", {31'b0, imem_req}, 32'h1);
        step();
        chk("hold_once", {31'b0, validD}, 32'h0);

        // 4: redirect while 0x10 is outstanding
        do_reset();
        echo = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drn_pre_addr", imem_addr, 32'h10);
        echo = 1'b0; imem_ready = 1'b0; PCsrcD = 1'b1; PCBranchD = 32'h100;
        step();
        PCsrcD = 1'b0;
        #1;
        chk("drn_flush", {31'b0, validD}, 32'h0);
        chk("drn_busy", {31'b0, fetch_busy}, 32'h1);
        chk("drn_addr_held", imem_addr, 32'h10);
        chk("drn_req", {31'b0, imem_req}, 32'h1);
        step();
        chk("drn_valid2", {31'b0, validD}, 32'h0);
        imem_ready = 1'b1; rdata_man = 32'h10;
        #1;
        chk("drn_busy_rdy", {31'b0, fetch_busy}, 32'h1);
        step();
        chk("drn_discard", {31'b0, validD}, 32'h0);
        chk("drn_target", imem_addr, 32'h100);
        echo = 1'b1;
        step();
        chk("drn_first", InstrD, 32'h100);
        chk("drn_first_v", {31'b0, validD}, 32'h1);

        // 5: redirect presented under stallD is ignored, then accepted
        PCsrcD = 1'b1; PCBranchD = 32'h200; stallD = 1'b1; stallF = 1'b1;
        step();
        chk("sd_hold_instr", InstrD, 32'h100);
        chk("sd_hold_valid", {31'b0, validD}, 32'h1);
        chk("sd_no_redirect", imem_addr, 32'h104);
        stallD = 1'b0; stallF = 1'b0;
        step();
        PCsrcD = 1'b0;
        chk("sd_flush_valid", {31'b0, validD}, 32'h0);
        chk("sd_flush_instr", InstrD, 32'h0);
        chk("sd_target", imem_addr, 32'h200);
        step();
        chk("sd_first", InstrD, 32'h200);

        // 6: reset while draining
        echo = 1'b0; imem_ready = 1'b0; PCsrcD = 1'b1; PCBranchD = 32'h300;
        step();
        PCsrcD = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("rd_in_drain", {31'b0, fetch_busy}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rd_addr", imem_addr, 32'h0);
        chk("rd_valid", {31'b0, validD}, 32'h0);
        chk("rd_fetch_state", {31'b0, fetch_busy}, 32'h0);
`ifdef FETCH_STAT_EN
        chk("rd_stat_redir", stat_redirects, 32'h0);
`endif

        // PC wrap at the top of the address space
        echo = 1'b1; PCsrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
        step();
        PCsrcD = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_instr", InstrD, 32'hFFFF_FFFC);
        chk("wrap_pcplus", PCPlus4D, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
